// File: rtl/echo_req_arbiter.sv
// Round-robin arbiter that shares one Echo request port among NUM_REQ clients and
// steers each in-order indication back to its issuer through a small tag FIFO.
module echo_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int DEPTH   = 4,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_REQ-1:0]      req_ena,
    input  logic [32*NUM_REQ-1:0]   req_meth,
    input  logic [32*NUM_REQ-1:0]   req_v,
    output logic [NUM_REQ-1:0]      req_rdy,
    output logic                    say_ena,
    output logic [31:0]             say_meth,
    output logic [31:0]             say_v,
    input  logic                    say_rdy,
    input  logic                    heard_ena,
    input  logic [31:0]             heard_meth,
    input  logic [31:0]             heard_v,
    output logic                    heard_rdy,
    output logic [NUM_REQ-1:0]      rsp_ena,
    output logic [31:0]             rsp_meth,
    output logic [31:0]             rsp_v,
    input  logic [NUM_REQ-1:0]      rsp_rdy,
    output logic [CW-1:0]           outstanding,
    output logic                    orphan_err
);

    logic [IDW-1:0] fifo_mem_reg [DEPTH];
    logic [PW-1:0]  rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [IDW-1:0] rr_ptr_reg;
    logic           orphan_err_reg;

    logic           fifo_empty, fifo_full;
    logic [IDW-1:0] head;
    logic           pop, push, can_issue, any_req;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] rr_ptr_next;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign head       = fifo_mem_reg[rd_ptr_reg];

    assign heard_rdy  = !fifo_empty & rsp_rdy[head];
    assign pop        = heard_ena & heard_rdy;
    // A full FIFO still accepts a new tag when the head is leaving in the same cycle.
    assign can_issue  = say_rdy & (!fifo_full | pop);
    assign any_req    = |req_ena;
    assign say_ena    = can_issue & any_req;
    assign push       = say_ena;

    // Search downward so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [IDW:0] idx;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NUM_REQ))
                idx = idx - (IDW+1)'(NUM_REQ);
            if (req_ena[idx[IDW-1:0]])
                winner = idx[IDW-1:0];
        end
    end

    assign say_meth    = any_req ? req_meth[32*winner +: 32] : '0;
    assign say_v       = any_req ? req_v[32*winner +: 32]    : '0;
    assign rr_ptr_next = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_rdy[gi] = say_ena & (winner == IDW'(gi));
            assign rsp_ena[gi] = heard_ena & !fifo_empty & (head == IDW'(gi));
        end
    endgenerate

    assign rsp_meth    = heard_meth;
    assign rsp_v       = heard_v;
    assign outstanding = count_reg;
    assign orphan_err  = orphan_err_reg;

    always_ff @(posedge CLK) begin
        if (push)
            fifo_mem_reg[wr_ptr_reg] <= winner;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            rr_ptr_reg     <= '0;
            orphan_err_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                rr_ptr_reg <= rr_ptr_next;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (heard_ena & fifo_empty)
                orphan_err_reg <= 1'b1;
        end
    end

endmodule

// File: tb/tb_echo_req_arbiter.sv
// Directed bench for echo_req_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_echo_req_arbiter;
    localparam int N = 4;
    localparam int D = 4;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic [N-1:0]    req_ena = '0;
    logic [32*N-1:0] req_meth = '0;
    logic [32*N-1:0] req_v = '0;
    logic [N-1:0]    req_rdy;
    logic            say_ena;
    logic [31:0]     say_meth, say_v;
    logic            say_rdy = 1'b1;
    logic            heard_ena = 1'b0;
    logic [31:0]     heard_meth = '0, heard_v = '0;
    logic            heard_rdy;
    logic [N-1:0]    rsp_ena;
    logic [31:0]     rsp_meth, rsp_v;
    logic [N-1:0]    rsp_rdy = '1;
    logic [2:0]      outstanding;
    logic            orphan_err;

    echo_req_arbiter #(.NUM_REQ(N), .IDW(2), .DEPTH(D)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ena(req_ena), .req_meth(req_meth), .req_v(req_v), .req_rdy(req_rdy),
        .say_ena(say_ena), .say_meth(say_meth), .say_v(say_v), .say_rdy(say_rdy),
        .heard_ena(heard_ena), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard_rdy(heard_rdy),
        .rsp_ena(rsp_ena), .rsp_meth(rsp_meth), .rsp_v(rsp_v), .rsp_rdy(rsp_rdy),
        .outstanding(outstanding), .orphan_err(orphan_err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    bit mdl_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: issuer IDs in order, round-robin start point, sticky orphan flag.
    int q[$];
    int m_rr = 0;
    bit m_orphan = 1'b0;

    function automatic int m_winner();
        for (int k = 0; k < N; k++)
            if (req_ena[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic bit m_pop();
        return heard_ena && q.size() > 0 && rsp_rdy[q[0]];
    endfunction

    function automatic bit m_push();
        return say_rdy && m_winner() >= 0 && (q.size() < D || m_pop());
    endfunction

    always @(posedge CLK) begin
        if (!nRST) begin
            q.delete();
            m_rr     <= 0;
            m_orphan <= 1'b0;
        end else begin
            if (heard_ena && q.size() == 0) m_orphan <= 1'b1;
            if (m_push()) m_rr <= (m_winner() + 1) % N;
            case ({m_push(), m_pop()})
                2'b11: begin void'(q.pop_front()); q.push_back(m_winner()); end
                2'b10: q.push_back(m_winner());
                2'b01: void'(q.pop_front());
                default: ;
            endcase
        end
    end

    always @(negedge CLK) begin
        if (mdl_en) begin
            logic [N-1:0] e_rdy, e_rsp;
            e_rdy = '0;
            e_rsp = '0;
            if (m_push()) e_rdy[m_winner()] = 1'b1;
            if (heard_ena && q.size() > 0) e_rsp[q[0]] = 1'b1;
            chk("m_req_rdy", req_rdy, e_rdy);
            chk("m_say_ena", say_ena, m_push());
            if (m_push()) begin
                chk("m_say_meth", say_meth, req_meth[32*m_winner() +: 32]);
                chk("m_say_v", say_v, req_v[32*m_winner() +: 32]);
            end
            chk("m_heard_rdy", heard_rdy, q.size() > 0 && rsp_rdy[q[0]]);
            chk("m_rsp_ena", rsp_ena, e_rsp);
            chk("m_rsp_meth", rsp_meth, heard_meth);
            chk("m_rsp_v", rsp_v, heard_v);
            chk("m_outstanding", outstanding, q.size());
            chk("m_orphan_err", orphan_err, m_orphan);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req_ena   = '0;
        say_rdy   = 1'b1;
        heard_ena = 1'b0;
        rsp_rdy   = '1;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        step();
        step();
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            req_meth[32*i +: 32] = 32'd5 + 32'(i);
            req_v[32*i +: 32]    = 32'h1234 + 32'h1000 * 32'(i);
        end
        do_reset();
        mdl_en = 1'b1;
        #1;
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", orphan_err, 0);
        chk("rst_req_rdy", req_rdy, 0);

        // Single request from requester 0, echoed back later.
        req_ena = 4'b0001;
        #1;
        chk("t1_say_ena", say_ena, 1);
        chk("t1_say_meth", say_meth, 5);
        chk("t1_say_v", say_v, 32'h1234);
        chk("t1_req_rdy", req_rdy, 4'b0001);
        step();
        req_ena = '0;
        #1;
        chk("t1_outstanding1", outstanding, 1);
        heard_ena = 1'b1; heard_meth = 5; heard_v = 32'h1234;
        #1;
        chk("t1_rsp_ena", rsp_ena, 4'b0001);
        chk("t1_rsp_v", rsp_v, 32'h1234);
        chk("t1_heard_rdy", heard_rdy, 1);
        step();
        heard_ena = 1'b0;
        #1;
        chk("t1_outstanding0", outstanding, 0);

        // All requesting: grants rotate 0,1,2,3,0; each response goes to its issuer.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req_ena = 4'b1111;
            heard_ena = (k > 0);
            heard_v = 32'hA0 + 32'(k);
            #1;
            chk("t2_req_rdy", req_rdy, 4'b0001 << (k % 4));
            if (k > 0) chk("t2_rsp_ena", rsp_ena, 4'b0001 << ((k - 1) % 4));
            step();
        end
        req_ena = '0;
        heard_ena = 1'b1;
        #1;
        chk("t2_rsp_last", rsp_ena, 4'b0001);
        step();
        heard_ena = 1'b0;
        #1;
        chk("t2_outstanding", outstanding, 0);

        // Fill with responses blocked: rr starts at 1, pushes 1,2,3,0.
        rsp_rdy = '0;
        req_ena = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_req_rdy", req_rdy, 4'b0001 << ((k + 1) % 4));
            step();
        end
        #1;
        chk("t3_full_req_rdy", req_rdy, 0);
        chk("t3_full_say_ena", say_ena, 0);
        chk("t3_outstanding", outstanding, 4);
        heard_ena = 1'b1;
        #1;
        chk("t3_heard_rdy", heard_rdy, 0);
        chk("t3_rsp_ena", rsp_ena, 4'b0010);
        step();
        chk("t3_still_full", outstanding, 4);

        // Full FIFO: push and pop together keep count at 4; order becomes 2,3,0,1.
        rsp_rdy = '1;
        #1;
        chk("t4_req_rdy", req_rdy, 4'b0010);
        chk("t4_rsp_ena", rsp_ena, 4'b0010);
        step();
        chk("t4_outstanding", outstanding, 4);
        req_ena = '0;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("t4_drain_rsp", rsp_ena, 4'b0001 << ((j + 2) % 4));
            step();
        end
        heard_ena = 1'b0;
        #1;
        chk("t4_empty", outstanding, 0);

        // Orphan indication at idle is refused and latched until reset.
        do_reset();
        heard_ena = 1'b1;
        #1;
        chk("t5_heard_rdy", heard_rdy, 0);
        chk("t5_orphan_before", orphan_err, 0);
        step();
        chk("t5_orphan_set", orphan_err, 1);
        heard_ena = 1'b0;
        repeat (3) step();
        chk("t5_orphan_hold", orphan_err, 1);

        // Reset with three outstanding clears state and rr pointer.
        req_ena = 4'b0111;
        repeat (3) step();
        req_ena = '0;
        #1;
        chk("t6_outstanding3", outstanding, 3);
        nRST = 1'b0;
        step();
        chk("t6_outstanding0", outstanding, 0);
        chk("t6_orphan", orphan_err, 0);
        chk("t6_req_rdy", req_rdy, 0);
        chk("t6_say_ena", say_ena, 0);
        chk("t6_rsp_ena", rsp_ena, 0);
        chk("t6_heard_rdy", heard_rdy, 0);
        nRST = 1'b1;
        req_ena = 4'b1111;
        #1;
        chk("t6_rr_zero", req_rdy, 4'b0001);
        step();
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
